// File: rtl/sd_spi_pkg.sv
// SD/SPI responder shared definitions: command indices, token values, FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package sd_spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] DRESP_OK    = 8'h05;
    localparam logic [7:0] BYTE_FILL   = 8'hFF;

    // Bit position of the illegal-command flag inside R1
    localparam int R1_ILLEGAL = 2;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_NCR, ST_RESP,
        ST_RD_NAC, ST_RD_TOKEN, ST_RD_DATA, ST_RD_CRC,
        ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_DRESP, ST_WR_BUSY
    } state_t;

    function automatic logic [7:0] r1_byte(input logic illegal, input logic idle);
        logic [7:0] r;
        r = 8'h00;
        r[R1_ILLEGAL] = illegal;
        r[0] = idle;
        return r;
    endfunction

endpackage

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte engine: synchronises cs/sclk/mosi, shifts rx on sclk rise, tx on sclk fall.
// Latency: rx_vld_o ~3 clk after the 8th sclk rise; tx_byte_i is loaded one clk after rx_vld_o or cs fall.
// Backpressure: none; the consumer must present tx_byte_i by the cycle byte_start_o is high.
// Ports: cs_i/sclk_i/mosi_i async SPI inputs, miso_o SPI output, cs_n_o synchronised chip select,
//        rx_byte_o/rx_vld_o received byte strobe, byte_start_o tx load point, tx_byte_i next byte to send.
module spi_byte_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic [7:0] tx_byte_i,
    output logic       miso_o,
    output logic       cs_n_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_vld_o,
    output logic       byte_start_o
);
    logic       cs_meta_q, cs_q, cs_prev_q;
    logic       sclk_meta_q, sclk_q, sclk_prev_q;
    logic       mosi_meta_q, mosi_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_sr_q;
    logic [7:0] tx_sr_q;
    logic [7:0] rx_byte_q;
    logic       rx_vld_q, byte_start_q;

    logic sclk_rise, sclk_fall, cs_fall;
    assign sclk_rise = sclk_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_q & sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q    <= 1'b1;
            cs_q         <= 1'b1;
            cs_prev_q    <= 1'b1;
            sclk_meta_q  <= 1'b0;
            sclk_q       <= 1'b0;
            sclk_prev_q  <= 1'b0;
            mosi_meta_q  <= 1'b1;
            mosi_q       <= 1'b1;
            bit_cnt_q    <= 3'd0;
            rx_sr_q      <= 7'd0;
            tx_sr_q      <= 8'hFF;
            rx_byte_q    <= 8'h00;
            rx_vld_q     <= 1'b0;
            byte_start_q <= 1'b0;
        end else begin
            cs_meta_q   <= cs_i;
            cs_q        <= cs_meta_q;
            cs_prev_q   <= cs_q;
            sclk_meta_q <= sclk_i;
            sclk_q      <= sclk_meta_q;
            sclk_prev_q <= sclk_q;
            mosi_meta_q <= mosi_i;
            mosi_q      <= mosi_meta_q;
            if (cs_q) begin
                bit_cnt_q    <= 3'd0;
                tx_sr_q      <= 8'hFF;
                rx_vld_q     <= 1'b0;
                byte_start_q <= 1'b0;
            end else begin
                rx_vld_q     <= 1'b0;
                byte_start_q <= rx_vld_q | cs_fall;
                if (sclk_rise) begin
                    rx_sr_q   <= {rx_sr_q[5:0], mosi_q};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_q <= {rx_sr_q, mosi_q};
                        rx_vld_q  <= 1'b1;
                    end
                end
                // No shift on the fall that closes a byte: the next byte is loaded instead
                if (byte_start_q)
                    tx_sr_q <= tx_byte_i;
                else if (sclk_fall && bit_cnt_q != 3'd0)
                    tx_sr_q <= {tx_sr_q[6:0], 1'b1};
            end
        end
    end

    assign miso_o       = cs_q ? 1'b1 : tx_sr_q[7];
    assign cs_n_o       = cs_q;
    assign rx_byte_o    = rx_byte_q;
    assign rx_vld_o     = rx_vld_q;
    assign byte_start_o = byte_start_q;
endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes commands, returns R1/R7, serves CMD17 reads and CMD24 writes.
// Latency: R1 after NCR_BYTES fill bytes; read data fetched one byte ahead of transmission.
// Backpressure: none; the SPI master paces everything, memory port must answer the clk after mem_rd_o.
// Ports: clk/rst_n, SPI cs/sclk/mosi/miso, byte-wide memory port mem_*, ready_o init done, busy_o transfer active.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int INIT_POLLS = 2,
    parameter int NCR_BYTES  = 1,
    parameter int NAC_BYTES  = 2,
    parameter int BUSY_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic [31:0] mem_blk_o,
    output logic [8:0]  mem_off_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_rdata_i,
    output logic        mem_wr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        ready_o,
    output logic        busy_o
);
    localparam logic [7:0] NCR_LAST  = 8'(NCR_BYTES - 1);
    localparam logic [7:0] NAC_LAST  = 8'(NAC_BYTES - 1);
    localparam logic [7:0] BUSY_LAST = 8'(BUSY_BYTES - 1);
    localparam logic [7:0] POLL_LIM  = 8'(INIT_POLLS);
    localparam logic [9:0] OFF_LAST  = 10'd511;

    logic       cs_n_s, rx_vld, byte_start;
    logic [7:0] rx_byte;

    state_t      state_q, after_q;
    logic [7:0]  tx_q, cnt_q, acnt_q, rd_buf_q;
    logic [5:0]  idx_q;
    logic [31:0] arg_q, resp_q;
    logic [2:0]  resp_left_q;
    logic [9:0]  off_q;
    logic        app_q, ready_q, busy_q, rd_pend_q;
    logic [31:0] mem_blk_q;
    logic [8:0]  mem_off_q;
    logic        mem_rd_q, mem_wr_q;
    logic [7:0]  mem_wdata_q;

    spi_byte_slave u_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_i         (cs),
        .sclk_i       (sclk),
        .mosi_i       (mosi),
        .tx_byte_i    (tx_q),
        .miso_o       (miso),
        .cs_n_o       (cs_n_s),
        .rx_byte_o    (rx_byte),
        .rx_vld_o     (rx_vld),
        .byte_start_o (byte_start)
    );

    // Response and side effects for the latched command, applied when NCR ends
    logic [7:0]  r1_d;
    logic [31:0] rest_d;
    logic [2:0]  rest_n_d;
    state_t      after_d;
    logic        accept_d, clr_init_d, poll_inc_d, set_ready_d;

    always_comb begin
        r1_d        = r1_byte(1'b1, ~ready_q);
        rest_d      = 32'd0;
        rest_n_d    = 3'd0;
        after_d     = ST_IDLE;
        accept_d    = 1'b0;
        clr_init_d  = 1'b0;
        poll_inc_d  = 1'b0;
        set_ready_d = 1'b0;
        case (idx_q)
            CMD0: begin
                r1_d       = 8'h01;
                clr_init_d = 1'b1;
            end
            CMD8: begin
                r1_d     = 8'h01;
                rest_d   = {8'h00, 8'h00, 8'h01, arg_q[7:0]};
                rest_n_d = 3'd4;
            end
            CMD16, CMD55: r1_d = r1_byte(1'b0, ~ready_q);
            CMD41: begin
                if (app_q) begin
                    if (acnt_q < POLL_LIM) begin
                        r1_d       = 8'h01;
                        poll_inc_d = 1'b1;
                    end else begin
                        r1_d        = 8'h00;
                        set_ready_d = 1'b1;
                    end
                end
            end
            CMD17, CMD24: begin
                if (ready_q) begin
                    r1_d     = 8'h00;
                    accept_d = 1'b1;
                    after_d  = (idx_q == CMD17) ? ST_RD_NAC : ST_WR_TOKEN;
                end else begin
                    r1_d = r1_byte(1'b1, 1'b1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            after_q     <= ST_IDLE;
            tx_q        <= BYTE_FILL;
            cnt_q       <= 8'd0;
            acnt_q      <= 8'd0;
            rd_buf_q    <= 8'h00;
            idx_q       <= 6'd0;
            arg_q       <= 32'd0;
            resp_q      <= 32'd0;
            resp_left_q <= 3'd0;
            off_q       <= 10'd0;
            app_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            mem_blk_q   <= 32'd0;
            mem_off_q   <= 9'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
        end else begin
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            rd_pend_q <= mem_rd_q;
            if (rd_pend_q)
                rd_buf_q <= mem_rdata_i;
            if (cs_n_s) begin
                state_q <= ST_IDLE;
                tx_q    <= BYTE_FILL;
                busy_q  <= 1'b0;
            end else begin
                // Fetch one byte ahead so rd_buf_q is ready at the next byte boundary
                if (byte_start) begin
                    if (state_q == ST_RD_TOKEN) begin
                        mem_rd_q  <= 1'b1;
                        mem_off_q <= 9'd0;
                    end else if (state_q == ST_RD_DATA && off_q != OFF_LAST) begin
                        mem_rd_q  <= 1'b1;
                        mem_off_q <= off_q[8:0] + 9'd1;
                    end
                end
                if (rx_vld) begin
                    tx_q <= BYTE_FILL;
                    case (state_q)
                        ST_IDLE: begin
                            if (rx_byte[7:6] == 2'b01) begin
                                idx_q   <= rx_byte[5:0];
                                cnt_q   <= 8'd0;
                                state_q <= ST_CMD;
                            end
                        end
                        ST_CMD: begin
                            if (cnt_q == 8'd4) begin
                                cnt_q   <= 8'd0;
                                state_q <= ST_NCR;
                            end else begin
                                arg_q <= {arg_q[23:0], rx_byte};
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_NCR: begin
                            if (cnt_q == NCR_LAST) begin
                                state_q     <= ST_RESP;
                                tx_q        <= r1_d;
                                resp_q      <= rest_d;
                                resp_left_q <= rest_n_d;
                                after_q     <= after_d;
                                app_q       <= (idx_q == CMD55);
                                cnt_q       <= 8'd0;
                                if (clr_init_d) begin
                                    ready_q <= 1'b0;
                                    acnt_q  <= 8'd0;
                                end
                                if (poll_inc_d)
                                    acnt_q <= acnt_q + 8'd1;
                                if (set_ready_d)
                                    ready_q <= 1'b1;
                                if (accept_d) begin
                                    busy_q    <= 1'b1;
                                    mem_blk_q <= arg_q;
                                end
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_RESP: begin
                            if (resp_left_q != 3'd0) begin
                                tx_q        <= resp_q[31:24];
                                resp_q      <= {resp_q[23:0], 8'h00};
                                resp_left_q <= resp_left_q - 3'd1;
                            end else begin
                                state_q <= after_q;
                                cnt_q   <= 8'd0;
                                off_q   <= 10'd0;
                            end
                        end
                        ST_RD_NAC: begin
                            if (cnt_q == NAC_LAST) begin
                                state_q <= ST_RD_TOKEN;
                                tx_q    <= TOKEN_START;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_RD_TOKEN: begin
                            state_q <= ST_RD_DATA;
                            tx_q    <= rd_buf_q;
                            off_q   <= 10'd0;
                        end
                        ST_RD_DATA: begin
                            if (off_q == OFF_LAST) begin
                                state_q <= ST_RD_CRC;
                                cnt_q   <= 8'd0;
                            end else begin
                                off_q <= off_q + 10'd1;
                                tx_q  <= rd_buf_q;
                            end
                        end
                        ST_RD_CRC: begin
                            if (cnt_q == 8'd1) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_WR_TOKEN: begin
                            if (rx_byte == TOKEN_START) begin
                                state_q <= ST_WR_DATA;
                                off_q   <= 10'd0;
                            end else if (rx_byte != BYTE_FILL) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                        ST_WR_DATA: begin
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= rx_byte;
                            mem_off_q   <= off_q[8:0];
                            if (off_q == OFF_LAST) begin
                                state_q <= ST_WR_CRC;
                                cnt_q   <= 8'd0;
                            end else begin
                                off_q <= off_q + 10'd1;
                            end
                        end
                        ST_WR_CRC: begin
                            if (cnt_q == 8'd1) begin
                                state_q <= ST_WR_DRESP;
                                tx_q    <= DRESP_OK;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                        ST_WR_DRESP: begin
                            state_q <= ST_WR_BUSY;
                            tx_q    <= 8'h00;
                            cnt_q   <= 8'd0;
                        end
                        ST_WR_BUSY: begin
                            if (cnt_q == BUSY_LAST) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                                tx_q  <= 8'h00;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign mem_blk_o   = mem_blk_q;
    assign mem_off_o   = mem_off_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: SPI master tasks, byte-wide memory model, hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_spi_responder;
    logic        clk = 1'b0;
    logic        rst_n, cs, sclk, mosi;
    logic        miso;
    logic [31:0] mem_blk_o;
    logic [8:0]  mem_off_o;
    logic        mem_rd_o, mem_wr_o;
    logic [7:0]  mem_rdata_i = 8'h00;
    logic [7:0]  mem_wdata_o;
    logic        ready_o, busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_spi_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .mem_blk_o   (mem_blk_o),
        .mem_off_o   (mem_off_o),
        .mem_rd_o    (mem_rd_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_wr_o    (mem_wr_o),
        .mem_wdata_o (mem_wdata_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    // Memory model: mem[n] = n[7:0]; counts strobes and flags out-of-order offsets or bad write data
    logic cnt_clr = 1'b0;
    int   rd_cnt = 0, rd_bad = 0, wr_cnt = 0, wr_bad = 0;

    always @(posedge clk) begin
        if (cnt_clr) begin
            rd_cnt <= 0; rd_bad <= 0; wr_cnt <= 0; wr_bad <= 0;
        end else begin
            if (mem_rd_o) begin
                mem_rdata_i <= mem_off_o[7:0];
                if (32'(mem_off_o) != rd_cnt) rd_bad <= rd_bad + 1;
                rd_cnt <= rd_cnt + 1;
            end
            if (mem_wr_o) begin
                if (32'(mem_off_o) != wr_cnt || mem_wdata_o != 8'hA5) wr_bad <= wr_bad + 1;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Sends a 6-byte frame, checks the single NCR filler, returns the first response byte
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, output logic [7:0] r1);
        logic [7:0] rx;
        xfer({2'b01, idx}, rx);
        xfer(arg[31:24], rx);
        xfer(arg[23:16], rx);
        xfer(arg[15:8], rx);
        xfer(arg[7:0], rx);
        xfer((idx == 6'd0) ? 8'h95 : 8'h01, rx);
        xfer(8'hFF, rx);
        check_eq("ncr_fill", {24'd0, rx}, 32'hFF);
        xfer(8'hFF, r1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"},  {31'd0, miso}, 32'd1);
        check_eq({tag, "_blk"},   mem_blk_o, 32'd0);
        check_eq({tag, "_off"},   {23'd0, mem_off_o}, 32'd0);
        check_eq({tag, "_rdwr"},  {30'd0, mem_rd_o, mem_wr_o}, 32'd0);
        check_eq({tag, "_wdata"}, {24'd0, mem_wdata_o}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, ready_o}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic [7:0] r, rx;
        logic [7:0] r7 [4];
        int bad;
        r7[0] = 8'h00; r7[1] = 8'h00; r7[2] = 8'h01; r7[3] = 8'hAA;

        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);

        send_cmd(6'd0, 32'h0, r);
        check_eq("cmd0_r1", {24'd0, r}, 32'h01);
        check_eq("cmd0_ready", {31'd0, ready_o}, 32'd0);

        send_cmd(6'd8, 32'h000001AA, r);
        check_eq("cmd8_r1", {24'd0, r}, 32'h01);
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, rx);
            check_eq("cmd8_r7", {24'd0, rx}, {24'd0, r7[i]});
        end

        send_cmd(6'd17, 32'd5, r);
        check_eq("cmd17_notready_r1", {24'd0, r}, 32'h05);
        xfer(8'hFF, rx);
        check_eq("cmd17_notready_nodata", {24'd0, rx}, 32'hFF);
        check_eq("cmd17_notready_busy", {31'd0, busy_o}, 32'd0);

        send_cmd(6'd41, 32'h40000000, r);
        check_eq("cmd41_noapp_r1", {24'd0, r}, 32'h05);
        send_cmd(6'd16, 32'd512, r);
        check_eq("cmd16_r1", {24'd0, r}, 32'h01);

        for (int i = 0; i < 3; i++) begin
            send_cmd(6'd55, 32'h0, r);
            check_eq("cmd55_r1", {24'd0, r}, 32'h01);
            send_cmd(6'd41, 32'h40000000, r);
            check_eq("acmd41_r1", {24'd0, r}, (i < 2) ? 32'h01 : 32'h00);
            check_eq("acmd41_ready", {31'd0, ready_o}, (i < 2) ? 32'd0 : 32'd1);
        end

        send_cmd(6'd58, 32'h0, r);
        check_eq("cmd58_illegal_r1", {24'd0, r}, 32'h04);

        // Block read
        clear_counts();
        send_cmd(6'd17, 32'd5, r);
        check_eq("cmd17_r1", {24'd0, r}, 32'h00);
        check_eq("cmd17_busy", {31'd0, busy_o}, 32'd1);
        xfer(8'hFF, rx); check_eq("cmd17_nac0", {24'd0, rx}, 32'hFF);
        xfer(8'hFF, rx); check_eq("cmd17_nac1", {24'd0, rx}, 32'hFF);
        xfer(8'hFF, rx); check_eq("cmd17_token", {24'd0, rx}, 32'hFE);
        bad = 0;
        for (int n = 0; n < 512; n++) begin
            xfer(8'hFF, rx);
            if (rx != 8'(n)) bad++;
        end
        check_eq("cmd17_data_bad", 32'(bad), 32'd0);
        xfer(8'hFF, rx); check_eq("cmd17_crc0", {24'd0, rx}, 32'hFF);
        xfer(8'hFF, rx); check_eq("cmd17_crc1", {24'd0, rx}, 32'hFF);
        repeat (8) @(negedge clk);
        check_eq("cmd17_blk", mem_blk_o, 32'd5);
        check_eq("cmd17_rd_cnt", 32'(rd_cnt), 32'd512);
        check_eq("cmd17_rd_order", 32'(rd_bad), 32'd0);
        check_eq("cmd17_busy_end", {31'd0, busy_o}, 32'd0);

        // Block write, with one filler before the token
        clear_counts();
        send_cmd(6'd24, 32'd9, r);
        check_eq("cmd24_r1", {24'd0, r}, 32'h00);
        xfer(8'hFF, rx);
        xfer(8'hFE, rx);
        for (int n = 0; n < 512; n++) xfer(8'hA5, rx);
        xfer(8'h12, rx);
        xfer(8'h34, rx);
        xfer(8'hFF, rx); check_eq("cmd24_dresp", {24'd0, rx}, 32'h05);
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, rx);
            check_eq("cmd24_busy_byte", {24'd0, rx}, 32'h00);
        end
        xfer(8'hFF, rx); check_eq("cmd24_done_byte", {24'd0, rx}, 32'hFF);
        check_eq("cmd24_blk", mem_blk_o, 32'd9);
        check_eq("cmd24_wr_cnt", 32'(wr_cnt), 32'd512);
        check_eq("cmd24_wr_bad", 32'(wr_bad), 32'd0);
        check_eq("cmd24_busy_end", {31'd0, busy_o}, 32'd0);

        // Abort a write after 100 bytes plus half a byte
        clear_counts();
        send_cmd(6'd24, 32'd9, r);
        check_eq("abort_r1", {24'd0, r}, 32'h00);
        xfer(8'hFE, rx);
        for (int n = 0; n < 100; n++) xfer(8'hA5, rx);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("abort_miso", {31'd0, miso}, 32'd1);
        check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
        check_eq("abort_wr_cnt", 32'(wr_cnt), 32'd100);
        check_eq("abort_wr_bad", 32'(wr_bad), 32'd0);
        check_eq("abort_ready_kept", {31'd0, ready_o}, 32'd1);

        // Asynchronous reset in the middle of a read
        cs = 1'b0;
        repeat (8) @(negedge clk);
        send_cmd(6'd17, 32'd5, r);
        check_eq("rst_cmd17_r1", {24'd0, r}, 32'h00);
        for (int n = 0; n < 13; n++) xfer(8'hFF, rx);
        check_eq("rst_pre_busy", {31'd0, busy_o}, 32'd1);
        mosi = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        sclk = 1'b0; cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
